// File: rtl/binary_tree_pkg.sv
// binary_tree_pkg: shared types and helpers for the
// mixer-tree dispense controller.
package binary_tree_pkg;

  localparam int NUM_TREES_DEF = 8;
  localparam int LEAVES_DEF    = 4;
  localparam int TREE_W        = $clog2(NUM_TREES_DEF);
  localparam int MAX_LEAVES    = 16;
  localparam int LEAF_W        = $clog2(MAX_LEAVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPENSE,
    S_MIX,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic              found;
    logic              last;
    logic [LEAF_W-1:0] idx;
  } leaf_sel_t;

  // Lowest set bit at or above cur; last = nothing set beyond it.
  function automatic leaf_sel_t next_set_bit(
    input logic [MAX_LEAVES-1:0] mask,
    input logic [LEAF_W:0]       cur
  );
    leaf_sel_t r;
    r      = '0;
    r.last = 1'b1;
    for (int i = 0; i < MAX_LEAVES; i++) begin
      if (mask[i] && (i >= int'(cur))) begin
        if (!r.found) begin
          r.found = 1'b1;
          r.idx   = LEAF_W'(i);
        end else begin
          r.last = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/binary_tree_dispense_ctrl_timer.sv
// dispense_timer: loadable down-counter with zero flag,
// shared by the dispense, mix and drain phases.
module dispense_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/binary_tree_dispense_ctrl.sv
// binary_tree_dispense_ctrl: sequences inlet, mix and drain
// valves of one mixer tree per accepted command.
module binary_tree_dispense_ctrl
  import binary_tree_pkg::*;
#(
  parameter int NUM_TREES       = NUM_TREES_DEF,
  parameter int LEAVES          = LEAVES_DEF,
  parameter int DISPENSE_CYCLES = 16,
  parameter int MIX_CYCLES      = 64,
  parameter int DRAIN_CYCLES    = 8,
  localparam int TW = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [TW-1:0]               cmd_tree,
  input  logic [LEAVES-1:0]           cmd_mask,
  input  logic                        abort,
  output logic [NUM_TREES*LEAVES-1:0] valve_in,
  output logic [NUM_TREES-1:0]        valve_out,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int MAXDM = (DISPENSE_CYCLES > MIX_CYCLES) ?
                         DISPENSE_CYCLES : MIX_CYCLES;
  localparam int MAXC  = (MAXDM > DRAIN_CYCLES) ?
                         MAXDM : DRAIN_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int VW    = NUM_TREES * LEAVES;

  state_e               state_q, state_d;
  logic [TW-1:0]        tree_q, tree_d;
  logic [LEAVES-1:0]    mask_q, mask_d;
  logic [LEAF_W-1:0]    leaf_q, leaf_d;
  logic                 last_q, last_d;
  logic [VW-1:0]        vin_q, vin_d;
  logic [NUM_TREES-1:0] vout_q, vout_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ld;
  logic [CW-1:0]        ld_val;
  logic                 tmr_zero;
  logic                 reject;
  leaf_sel_t            sel0, seln;

  dispense_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ld),
    .val_i  (ld_val),
    .zero_o (tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    tree_d  = tree_q;
    mask_d  = mask_q;
    leaf_d  = leaf_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    sel0    = next_set_bit(MAX_LEAVES'(cmd_mask), '0);
    seln    = next_set_bit(MAX_LEAVES'(mask_q),
                {1'b0, leaf_q} + (LEAF_W+1)'(1));
    reject  = !sel0.found || (int'(cmd_tree) >= NUM_TREES);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && reject) begin
          err_d = 1'b1;
        end else if (cmd_valid) begin
          state_d = S_DISPENSE;
          tree_d  = cmd_tree;
          mask_d  = cmd_mask;
          leaf_d  = sel0.idx;
          last_d  = sel0.last;
          ld      = 1'b1;
          ld_val  = CW'(DISPENSE_CYCLES - 1);
        end
      end
      S_DISPENSE: begin
        if (tmr_zero && (last_q || !seln.found)) begin
          state_d = S_MIX;
          ld      = 1'b1;
          ld_val  = CW'(MIX_CYCLES - 1);
        end else if (tmr_zero) begin
          leaf_d = seln.idx;
          last_d = seln.last;
          ld     = 1'b1;
          ld_val = CW'(DISPENSE_CYCLES - 1);
        end
      end
      S_MIX: begin
        if (tmr_zero) begin
          state_d = S_DRAIN;
          ld      = 1'b1;
          ld_val  = CW'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        if (tmr_zero) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any phase expiry in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      ld      = 1'b0;
    end

    vin_d  = '0;
    vout_d = '0;
    if (state_d == S_DISPENSE) begin
      vin_d = VW'(1) << (int'(tree_d) * LEAVES + int'(leaf_d));
    end
    if (state_d == S_DRAIN) begin
      vout_d = NUM_TREES'(1) << tree_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tree_q  <= '0;
      mask_q  <= '0;
      leaf_q  <= '0;
      last_q  <= 1'b0;
      vin_q   <= '0;
      vout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tree_q  <= tree_d;
      mask_q  <= mask_d;
      leaf_q  <= leaf_d;
      last_q  <= last_d;
      vin_q   <= vin_d;
      vout_q  <= vout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign valve_in  = vin_q;
  assign valve_out = vout_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_binary_tree_dispense_ctrl.sv
// tb_binary_tree_dispense_ctrl: scoreboard bench for the
// dispense controller (valve change and pulse queues).
module tb_binary_tree_dispense_ctrl;
  import binary_tree_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [TREE_W-1:0] cmd_tree = '0;
  logic [3:0]  cmd_mask = '0;
  logic        abort = 1'b0;
  logic [31:0] valve_in;
  logic [7:0]  valve_out;
  logic        busy, done, err;

  logic        c6_valid = 1'b0;
  logic        c6_ready;
  logic [2:0]  c6_tree = '0;
  logic [3:0]  c6_mask = '0;
  logic        c6_abort = 1'b0;
  logic [23:0] c6_vin;
  logic [5:0]  c6_vout;
  logic        c6_busy, c6_done, c6_err;

  binary_tree_dispense_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tree(cmd_tree), .cmd_mask(cmd_mask),
    .abort(abort),
    .valve_in(valve_in), .valve_out(valve_out),
    .busy(busy), .done(done), .err(err)
  );

  binary_tree_dispense_ctrl #(
    .NUM_TREES(6), .LEAVES(4),
    .DISPENSE_CYCLES(2), .MIX_CYCLES(2), .DRAIN_CYCLES(2)
  ) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c6_valid), .cmd_ready(c6_ready),
    .cmd_tree(c6_tree), .cmd_mask(c6_mask),
    .abort(c6_abort),
    .valve_in(c6_vin), .valve_out(c6_vout),
    .busy(c6_busy), .done(c6_done), .err(c6_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [31:0] vi;
    logic [7:0]  vo;
  } vev_t;

  typedef struct {
    int c;
    bit d;
  } pev_t;

  vev_t vq[$];
  pev_t pq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic [39:0] prev = '0;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Expected valve changes and done pulse for a normal run.
  task automatic expect_cmd(input int a, input int tree,
                            input logic [3:0] mask);
    int c;
    if (mask == 4'd0) begin
      pq.push_back('{a + 1, 1'b0});
      return;
    end
    c = a + 1;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        vq.push_back('{c, 32'd1 << (tree * 4 + k), 8'd0});
        c += 16;
      end
    end
    vq.push_back('{c, 32'd0, 8'd0});
    c += 64;
    vq.push_back('{c, 32'd0, 8'd1 << tree});
    c += 8;
    vq.push_back('{c, 32'd0, 8'd0});
    pq.push_back('{c, 1'b1});
  endtask

  task automatic send(input int tree, input logic [3:0] mask,
                      input bit ab, input bit keep,
                      input bit push, output int a);
    bit got;
    got = 1'b0;
    a = 0;
    cmd_valid = 1'b1;
    cmd_tree  = TREE_W'(tree);
    cmd_mask  = mask;
    abort     = ab;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk(1'b0, "accept_timeout", 0, 1);
    a = cyc;
    if (push) expect_cmd(a, tree, mask);
    @(negedge clk);
    abort = 1'b0;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk(1'b0, "idle_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    vev_t e;
    pev_t p;
    if (mon_en) begin
      if ({valve_in, valve_out} !== prev) begin
        if (vq.size() == 0) begin
          chk(1'b0, "valve_unexpected",
              {valve_in, valve_out}, prev);
        end else begin
          e = vq.pop_front();
          chk(e.c == cyc, "valve_time", cyc, e.c);
          chk({valve_in, valve_out} === {e.vi, e.vo},
              "valve_value", {valve_in, valve_out},
              {e.vi, e.vo});
        end
        prev = {valve_in, valve_out};
      end
      if (done || err) begin
        if (pq.size() == 0) begin
          chk(1'b0, "pulse_unexpected", {done, err}, 0);
        end else begin
          p = pq.pop_front();
          chk(p.c == cyc, "pulse_time", cyc, p.c);
          chk({done, err} === {p.d, !p.d}, "pulse_kind",
              {done, err}, {p.d, !p.d});
        end
      end
      chk($onehot0(valve_in), "vin_onehot0", valve_in, 0);
      chk(!((|valve_in) && (|valve_out)), "vin_vout_excl",
          {valve_in, valve_out}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2;
    repeat (2) @(negedge clk);
    chk(valve_in == 32'd0, "rst_vin", valve_in, 0);
    chk(valve_out == 8'd0, "rst_vout", valve_out, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(done == 1'b0, "rst_done", done, 0);
    chk(err == 1'b0, "rst_err", err, 0);
    chk(cmd_ready == 1'b1, "rst_ready", cmd_ready, 1);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    repeat (20) @(negedge clk);
    chk({valve_in, valve_out} == 40'd0, "quiet_after_rst",
        {valve_in, valve_out}, 0);

    send(3, 4'b1111, 1'b0, 1'b0, 1'b1, a);
    wait_idle();

    send(7, 4'b1010, 1'b0, 1'b0, 1'b1, a);
    wait_idle();

    send(2, 4'b0000, 1'b0, 1'b0, 1'b1, a);
    chk(busy == 1'b0, "reject_idle", busy, 0);
    repeat (3) @(negedge clk);

    send(0, 4'b0011, 1'b0, 1'b0, 1'b0, a);
    vq.push_back('{a + 1, 32'd1, 8'd0});
    vq.push_back('{a + 17, 32'd2, 8'd0});
    vq.push_back('{a + 21, 32'd0, 8'd0});
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk(cmd_ready == 1'b1, "abort_ready", cmd_ready, 1);
    chk(busy == 1'b0, "abort_busy", busy, 0);
    repeat (3) @(negedge clk);

    send(5, 4'b0100, 1'b1, 1'b0, 1'b1, a);
    wait_idle();

    send(1, 4'b0001, 1'b0, 1'b1, 1'b1, a);
    send(6, 4'b1000, 1'b0, 1'b0, 1'b1, a2);
    chk(a2 == a + 90, "b2b_accept", a2, a + 90);
    wait_idle();

    c6_valid = 1'b1;
    c6_tree  = 3'd7;
    c6_mask  = 4'b0001;
    chk(c6_ready == 1'b1, "t6_ready", c6_ready, 1);
    @(negedge clk);
    c6_valid = 1'b0;
    chk(c6_err == 1'b1, "t6_err", c6_err, 1);
    chk(c6_vin == 24'd0, "t6_novalve", c6_vin, 0);
    chk(c6_busy == 1'b0, "t6_idle", c6_busy, 0);
    @(negedge clk);
    chk(c6_err == 1'b0, "t6_err_pulse", c6_err, 0);
    c6_valid = 1'b1;
    c6_tree  = 3'd5;
    @(negedge clk);
    c6_valid = 1'b0;
    chk(c6_err == 1'b0, "t6_ok_noerr", c6_err, 0);
    chk(c6_vin == 24'h100000, "t6_vin", c6_vin, 24'h100000);
    repeat (12) @(negedge clk);
    chk(c6_busy == 1'b0, "t6_finished", c6_busy, 0);

    send(4, 4'b0001, 1'b0, 1'b0, 1'b1, a);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(valve_in == 32'd0, "async_rst_vin", valve_in, 0);
    chk(busy == 1'b0, "async_rst_busy", busy, 0);
    chk(cmd_ready == 1'b1, "async_rst_ready", cmd_ready, 1);
    vq.delete();
    pq.delete();
    vq.push_back('{cyc, 32'd0, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    chk(vq.size() == 0, "vq_drained", vq.size(), 0);
    chk(pq.size() == 0, "pq_drained", pq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
